// File: rtl/fsmd_pkg.sv
// Shared types and constants for the fsmd host-side sequencer.
// The host FSM state type lives here so the bench and any other users of the
// fsmd port can name the same states.
package fsmd_pkg;

  localparam int FSMD_HOST_DEPTH_DEFAULT = 4;
  localparam int FSMD_DATA_W             = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } host_state_t;

endpackage

// File: rtl/fsmd_host_if.sv
// Bundle of the producer, FSMD and consumer signals seen by fsmd_host.
// master: the view of fsmd_host itself; slave: the view of its surroundings.
interface fsmd_host_if;
  import fsmd_pkg::*;

  logic [FSMD_DATA_W-1:0] op_in;
  logic                   op_valid_in;
  logic                   op_ready_out;
  logic [FSMD_DATA_W-1:0] fsmd_ext_out;
  logic                   fsmd_ready_in;
  logic                   fsmd_done_in;
  logic [FSMD_DATA_W-1:0] fsmd_ext_in;
  logic [FSMD_DATA_W-1:0] res_out;
  logic                   res_valid_out;
  logic                   res_ready_in;
  logic                   busy_out;
  logic                   err_out;
  logic                   timeout_out;

  modport master (
    input  op_in, op_valid_in, fsmd_ready_in, fsmd_done_in, fsmd_ext_in, res_ready_in,
    output op_ready_out, fsmd_ext_out, res_out, res_valid_out, busy_out, err_out, timeout_out
  );

  modport slave (
    output op_in, op_valid_in, fsmd_ready_in, fsmd_done_in, fsmd_ext_in, res_ready_in,
    input  op_ready_out, fsmd_ext_out, res_out, res_valid_out, busy_out, err_out, timeout_out
  );

endinterface

// File: rtl/fsmd_host_fifo.sv
// Operand FIFO for fsmd_host. DEPTH must be a power of two so the pointers
// wrap naturally; an occupancy counter distinguishes full from empty.
module fsmd_host_fifo
  import fsmd_pkg::*;
#(
  parameter int DEPTH = FSMD_HOST_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [FSMD_DATA_W-1:0] i_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [FSMD_DATA_W-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [FSMD_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; push and pop on one edge cancel in the count.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are meaningless while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fsmd_host.sv
// Host-side sequencer for the fsmd external port: queues operands, issues one
// at a time while the FSMD is ready, captures its result and offers it to a
// valid/ready consumer.
// Optional watchdog on the wait for done_out: define FSMD_HOST_TIMEOUT_EN.
module fsmd_host
  import fsmd_pkg::*;
#(
  parameter int DEPTH          = FSMD_HOST_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         srst,
  fsmd_host_if.master bus
);

  host_state_t            r_state;
  host_state_t            w_next;
  logic [FSMD_DATA_W-1:0] r_ext_out;
  logic [FSMD_DATA_W-1:0] r_res;
  logic                   r_res_valid;
  logic                   r_err;
  logic                   w_full;
  logic                   w_empty;
  logic [FSMD_DATA_W-1:0] w_head;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue_done;
  logic                   w_done;
  logic                   w_to_hit;
  logic                   w_expire;

  // Zero operands complete the handshake but never enter the queue: a zero on
  // ext_in would leave the FSMD idle and the host waiting forever.
  assign w_accept = bus.op_valid_in & ~w_full;
  assign w_push   = w_accept & (bus.op_in != '0);

  fsmd_host_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.op_in),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef FSMD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  assign w_to_hit = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: restart on entry to WAIT_DONE, count every cycle spent there.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_issue_done)              r_to_cnt <= '0;
      else if (r_state == WAIT_DONE) r_to_cnt <= r_to_cnt + 1'b1;
      if (w_expire)                  r_timeout <= 1'b1;
    end
  end

  assign bus.timeout_out = r_timeout;
`else
  assign w_to_hit        = 1'b0;
  // Watchdog compiled out; the parameter is referenced so it stays legal to set.
  assign bus.timeout_out = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (srst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and strobe decode. A held result blocks issue unless it is
  // being accepted on this same edge; done beats watchdog expiry.
  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_issue_done = 1'b0;
    w_done       = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && (!r_res_valid || bus.res_ready_in)) begin
          w_next = ISSUE;
          w_pop  = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.fsmd_ready_in) begin
          w_next       = WAIT_DONE;
          w_issue_done = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.fsmd_done_in) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (w_to_hit) begin
          w_next   = IDLE;
          w_expire = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand and result data registers; ext_out is zero whenever not issuing.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_ext_out <= '0;
      r_res     <= '0;
    end else begin
      if (w_pop)             r_ext_out <= w_head;
      else if (w_issue_done) r_ext_out <= '0;
      if (w_done)            r_res <= bus.fsmd_ext_in;
    end
  end

  // Result valid flag and sticky zero-operand error.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_done)                r_res_valid <= 1'b1;
      else if (bus.res_ready_in) r_res_valid <= 1'b0;
      if (w_accept && (bus.op_in == '0)) r_err <= 1'b1;
    end
  end

  assign bus.op_ready_out  = ~w_full;
  assign bus.busy_out      = (r_state != IDLE);
  assign bus.fsmd_ext_out  = r_ext_out;
  assign bus.res_out       = r_res;
  assign bus.res_valid_out = r_res_valid;
  assign bus.err_out       = r_err;

endmodule

// File: tb/tb_fsmd_host.sv
// Bench for fsmd_host with a small behavioural FSMD (result = operand >> 3,
// done three cycles after the operand is sampled) and issue/result scoreboards.
module tb_fsmd_host;
  import fsmd_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  fsmd_host_if bus ();

  fsmd_host #(.DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [7];

  logic [15:0] iss_q [$];
  logic [15:0] res_q [$];

  // FSMD model controls
  logic        fm_gate  = 1'b0;
  logic        fm_hang  = 1'b0;
  logic        fm_force = 1'b0;
  logic        fm_busy, fm_done;
  logic [1:0]  fm_cnt;
  logic [15:0] fm_op, fm_res;

  assign bus.fsmd_ready_in = fm_gate & ~fm_busy;
  assign bus.fsmd_done_in  = fm_done | fm_force;
  assign bus.fsmd_ext_in   = fm_force ? 16'hBEEF : fm_res;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FSMD
  always @(posedge clk) begin
    if (srst) begin
      fm_busy <= 1'b0;
      fm_done <= 1'b0;
      fm_cnt  <= 2'd0;
      fm_res  <= 16'h0;
      fm_op   <= 16'h0;
    end else begin
      fm_done <= 1'b0;
      if (fm_busy) begin
        if (!fm_hang) begin
          if (fm_cnt == 2'd1) begin
            fm_busy <= 1'b0;
            fm_done <= 1'b1;
            fm_res  <= fm_op >> 3;
          end else begin
            fm_cnt <= fm_cnt - 2'd1;
          end
        end
      end else if (fm_gate && bus.fsmd_ext_out != '0) begin
        fm_busy <= 1'b1;
        fm_cnt  <= 2'd3;
        fm_op   <= bus.fsmd_ext_out;
      end
    end
  end

  // Scoreboard monitor: looks at what the next rising edge will transfer
  always @(negedge clk) begin
    if (!srst) begin
      if (bus.fsmd_ready_in && bus.fsmd_ext_out != '0) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue: unexpected operand %h", bus.fsmd_ext_out);
        end else begin
          chk("issue", bus.fsmd_ext_out, iss_q.pop_front());
        end
      end
      if (bus.res_valid_out && bus.res_ready_in) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result: unexpected result %h", bus.res_out);
        end else begin
          chk("result", bus.res_out, res_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [15:0] op, input logic [15:0] exp, input bit want_res);
    int n = 0;
    bus.op_in       = op;
    bus.op_valid_in = 1'b1;
    while (!bus.op_ready_out && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.op_ready_out) begin
      errors++;
      $display("FAIL push_wait: op_ready stuck 0 for op %h", op);
    end else if (op != 16'h0) begin
      iss_q.push_back(op);
      if (want_res) res_q.push_back(exp);
    end
    tick();
    bus.op_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((res_q.size() != 0 || iss_q.size() != 0 || bus.busy_out || bus.res_valid_out) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_res_q", 16'(res_q.size()), 16'h0);
    chk("drain_iss_q", 16'(iss_q.size()), 16'h0);
  endtask

  task automatic wait_wait_done(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (bus.fsmd_ext_out == '0 && n < 50) begin tick(); n++; end
    if (bus.fsmd_ext_out == '0) ok = 1'b0;
    n = 0;
    while (bus.fsmd_ext_out != '0 && n < 50) begin tick(); n++; end
    if (bus.fsmd_ext_out != '0) ok = 1'b0;
    chk1("reach_wait_done", ok, 1'b1);
  endtask

  task automatic reset_pulse();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;

    tbl[0] = '{16'h0030, 16'h0006};
    tbl[1] = '{16'h1234, 16'h0246};
    tbl[2] = '{16'hFFF8, 16'h1FFF};
    tbl[3] = '{16'h0008, 16'h0001};
    tbl[4] = '{16'h8000, 16'h1000};
    tbl[5] = '{16'h00A0, 16'h0014};
    tbl[6] = '{16'h7FF0, 16'h0FFE};

    bus.op_in        = 16'h0;
    bus.op_valid_in  = 1'b0;
    bus.res_ready_in = 1'b0;
    srst             = 1'b1;
    repeat (3) tick();

    // Reset values
    chk1("rst_op_ready", bus.op_ready_out, 1'b1);
    chk1("rst_busy", bus.busy_out, 1'b0);
    chk("rst_ext", bus.fsmd_ext_out, 16'h0);
    chk("rst_res", bus.res_out, 16'h0);
    chk1("rst_res_valid", bus.res_valid_out, 1'b0);
    chk1("rst_err", bus.err_out, 1'b0);
    chk1("rst_timeout", bus.timeout_out, 1'b0);
    srst = 1'b0;
    tick();

    // Single operand with cycle-exact issue timing; result held afterwards
    fm_gate = 1'b1;
    push_op(tbl[0].op, tbl[0].exp, 1'b1);
    chk("single_ext_k", bus.fsmd_ext_out, 16'h0);
    chk1("single_busy_k", bus.busy_out, 1'b0);
    tick();
    chk1("single_busy_k1", bus.busy_out, 1'b1);
    chk("single_ext_k1", bus.fsmd_ext_out, 16'h0030);
    tick();
    chk("single_ext_k2", bus.fsmd_ext_out, 16'h0);
    chk1("single_busy_k2", bus.busy_out, 1'b1);
    n = 0;
    while (!bus.res_valid_out && n < 20) begin tick(); n++; end
    chk1("single_res_valid", bus.res_valid_out, 1'b1);
    chk("single_res", bus.res_out, 16'h0006);
    chk1("single_busy_after", bus.busy_out, 1'b0);

    // Fill while the result is held: four operands fill the FIFO
    fm_gate = 1'b0;
    for (int i = 0; i < 4; i++) push_op(tbl[i].op, tbl[i].exp, 1'b1);
    chk1("fill_full", bus.op_ready_out, 1'b0);
    bus.op_in       = tbl[4].op;
    bus.op_valid_in = 1'b1;
    repeat (3) begin
      tick();
      chk1("fill_still_full", bus.op_ready_out, 1'b0);
      chk("fill_held_ext", bus.fsmd_ext_out, 16'h0);
    end
    // Accepting the held result lets the issue proceed on the same edge
    bus.res_ready_in = 1'b1;
    tick();
    chk1("fill_issue_busy", bus.busy_out, 1'b1);
    chk("fill_issue_ext", bus.fsmd_ext_out, tbl[0].op);
    chk1("fill_res_cleared", bus.res_valid_out, 1'b0);
    chk1("fill_slot_free", bus.op_ready_out, 1'b1);
    iss_q.push_back(tbl[4].op);
    res_q.push_back(tbl[4].exp);
    tick();
    bus.op_valid_in = 1'b0;
    chk1("fill_full_again", bus.op_ready_out, 1'b0);
    chk("fill_issue_hold", bus.fsmd_ext_out, tbl[0].op);
    fm_gate = 1'b1;
    wait_drain(400);

    // Backpressure: second operand waits for the first result to be taken
    bus.res_ready_in = 1'b0;
    push_op(tbl[5].op, tbl[5].exp, 1'b1);
    push_op(tbl[6].op, tbl[6].exp, 1'b1);
    n = 0;
    while (!bus.res_valid_out && n < 30) begin tick(); n++; end
    chk1("bp_res_valid", bus.res_valid_out, 1'b1);
    repeat (4) begin
      tick();
      chk("bp_ext_zero", bus.fsmd_ext_out, 16'h0);
      chk1("bp_idle", bus.busy_out, 1'b0);
    end
    chk("bp_res", bus.res_out, tbl[5].exp);
    bus.res_ready_in = 1'b1;
    wait_drain(200);

    // Table stream with consumer always ready
    for (int i = 0; i < 7; i++) push_op(tbl[i].op, tbl[i].exp, 1'b1);
    wait_drain(600);

    // Zero drop
    push_op(16'h0000, 16'h0000, 1'b0);
    chk1("zero_err", bus.err_out, 1'b1);
    push_op(16'h0007, 16'h0000, 1'b1);
    wait_drain(100);
    chk1("zero_err_sticky", bus.err_out, 1'b1);

    // Reset while waiting for done
    push_op(16'h0100, 16'h0020, 1'b0);
    wait_wait_done(ok);
    chk1("rwd_busy_before", bus.busy_out, 1'b1);
    reset_pulse();
    chk1("rwd_op_ready", bus.op_ready_out, 1'b1);
    chk1("rwd_busy", bus.busy_out, 1'b0);
    chk("rwd_ext", bus.fsmd_ext_out, 16'h0);
    chk("rwd_res", bus.res_out, 16'h0);
    chk1("rwd_res_valid", bus.res_valid_out, 1'b0);
    chk1("rwd_err", bus.err_out, 1'b0);
    chk1("rwd_timeout", bus.timeout_out, 1'b0);
    fm_force = 1'b1;
    tick();
    fm_force = 1'b0;
    tick();
    chk1("rwd_late_done_valid", bus.res_valid_out, 1'b0);
    chk("rwd_late_done_res", bus.res_out, 16'h0);

    // Watchdog: FSMD never answers
    fm_hang = 1'b1;
    push_op(16'h0200, 16'h0040, 1'b0);
    wait_wait_done(ok);
`ifdef FSMD_HOST_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk1("to_not_yet", bus.timeout_out, 1'b0);
    chk1("to_still_busy", bus.busy_out, 1'b1);
    tick();
    chk1("to_set", bus.timeout_out, 1'b1);
    chk1("to_idle", bus.busy_out, 1'b0);
    chk1("to_no_result", bus.res_valid_out, 1'b0);
    repeat (2) tick();
    chk1("to_sticky", bus.timeout_out, 1'b1);
`else
    repeat (TO + 4) tick();
    chk1("to_off_flag", bus.timeout_out, 1'b0);
    chk1("to_off_waiting", bus.busy_out, 1'b1);
`endif
    fm_hang = 1'b0;
    reset_pulse();
    chk1("final_timeout_clear", bus.timeout_out, 1'b0);
    chk("final_res_q", 16'(res_q.size()), 16'h0);
    chk("final_iss_q", 16'(iss_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, reached %0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/fsmd_host.md
# fsmd_host

Host-side sequencer for the `fsmd` external port, sitting between a producer of 16-bit operands and the FSMD. It buffers operands in a small FIFO and presents each one on the FSMD's `ext_in` only while the FSMD is ready. It then waits for `done_out`, captures `ext_out`, and hands the result to a downstream consumer through a valid/ready handshake.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles; used only with `FSMD_HOST_TIMEOUT_EN`.

- `clk`  in  1  system clock, rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `op_in`  in  16  operand from producer.
- `op_valid_in`  in  1  operand valid.
- `op_ready_out`  out  1  FIFO can accept; equals `!full`.
- `fsmd_ext_out`  out  16  to FSMD `ext_in`; registered.
- `fsmd_ready_in`  in  1  from FSMD `ready_out`.
- `fsmd_done_in`  in  1  from FSMD `done_out`.
- `fsmd_ext_in`  in  16  from FSMD `ext_out`.
- `res_out`  out  16  captured result; registered.
- `res_valid_out`  out  1  result valid.
- `res_ready_in`  in  1  consumer accepts result.
- `busy_out`  out  1  state ≠ IDLE.
- `err_out`  out  1  sticky: a zero operand was dropped.
- `timeout_out`  out  1  sticky: watchdog expired.

## Operation
- **FSMD protocol (fixed):**
  - The FSMD samples `ext_in` on every edge where `ready_out`=1.
  - A nonzero sample starts a computation; zero keeps the FSMD idle.
  - `done_out` is a 1-cycle pulse with `ext_out` valid in the same cycle.
  - The host therefore drives `fsmd_ext_out`=0 whenever it is not issuing.
- **Operand accept:** on an edge where `op_valid_in & op_ready_out`:
  - if `op_in`≠0, the operand is pushed into the FIFO;
  - if `op_in`==0, the handshake completes, the operand is dropped and `err_out` is set.
- **State machine** (`host_state_t`: IDLE, ISSUE, WAIT_DONE):
  - **IDLE → ISSUE:** when the FIFO is non-empty and `res_valid_out`=0. At that edge the FIFO head is popped into `fsmd_ext_out`.
  - **ISSUE → WAIT_DONE:** on an edge with `fsmd_ready_in`=1. At that edge `fsmd_ext_out` is cleared to 0.
  - **WAIT_DONE → IDLE:** on an edge with `fsmd_done_in`=1. At that edge `res_out` ← `fsmd_ext_in` and `res_valid_out` ← 1.
  - `fsmd_done_in` in IDLE or ISSUE is ignored.
- **Result handshake:**
  - `res_valid_out` clears on an edge with `res_ready_in`=1.
  - `res_out` holds its value until it is next loaded.
- **Issue blocking:** a held result blocks the next issue. Exception: in IDLE, if `res_valid_out & res_ready_in` on the same edge, the issue proceeds on that edge.
- **FIFO boundaries:**
  - Full: `op_ready_out`=0 and no push. A pop frees the slot from the next cycle.
  - Push and pop on the same edge (not full): both take effect.
  - Pointers wrap modulo `DEPTH`.
- **Reset values** (`srst` at any time, including mid-operation):
  - state = IDLE, FIFO empty.
  - `fsmd_ext_out`=0, `res_out`=0, `res_valid_out`=0, `err_out`=0, `timeout_out`=0, `busy_out`=0.
  - `op_ready_out`=1.
  - The FSMD is reset by the same `srst`.

## Timing
- Operand pushed at edge k: earliest, state=ISSUE and `fsmd_ext_out` = operand after edge k+1.
- The FSMD sees the operand from the first `fsmd_ready_in` edge ≥ k+2.
- `done` sampled at edge d: `res_valid_out`=1 after d. The next issue is possible at edge d+1 if the result is accepted at d+1.
- All outputs are registered except `op_ready_out` and `busy_out`, which are decoded from registers only (no combinational input-to-output path).

## Configuration
- **`FSMD_HOST_TIMEOUT_EN` defined:**
  - A cycle counter is cleared on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches `TIMEOUT_CYCLES`-1 without `fsmd_done_in`, the next edge sets `timeout_out`, returns to IDLE and produces no result.
  - If `done` and expiry occur on the same edge, `done` wins.
- **Undefined:**
  - No counter; WAIT_DONE waits indefinitely.
  - `timeout_out` is tied to 0; the port is still present.

## Structure
- Add `host_state_t` and `FSMD_HOST_DEPTH_DEFAULT` to `fsmd_pkg`.
- Sub-module `fsmd_host_fifo` (parameter `DEPTH`; push/pop/full/empty/head); the FSM and result register are in `fsmd_host`.

## Test plan
- **Single operand:** reset, push 0x0030; FSMD model asserts `ready` and returns `done` with 0x0006 three cycles later.
  - `fsmd_ext_out`=0x0030 only in ISSUE; `res_out`=0x0006 with `res_valid_out`=1.
- **Fill and drain:** push 5 operands with `DEPTH`=4 while `fsmd_ready_in`=0.
  - `op_ready_out` drops after 4 pushes.
  - Once `ready` is released, results arrive in push order.
- **Backpressure:** hold `res_ready_in`=0 with 2 operands queued.
  - The second operand is not issued (`fsmd_ext_out` stays 0) until the result is accepted.
- **Zero drop:** push 0x0000 then 0x0007.
  - `err_out`=1 sticky; only 0x0007 is issued.
- **Reset in WAIT_DONE:**
  - All outputs return to their reset values.
  - A later `fsmd_done_in` pulse produces no result.
- **Timeout:** with `FSMD_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, never assert `done`.
  - `timeout_out`=1 and state=IDLE 16 cycles after WAIT_DONE is entered.
